// File: rtl/sng_lfsr_bank.sv
// Multi-channel stochastic number generator: one Fibonacci LFSR and comparator per channel,
// producing STREAM_LEN-bit unipolar streams plus per-channel ones counters.
module sng_lfsr_bank #(
    parameter int               WIDTH      = 8,
    parameter int               CHANNELS   = 2,
    parameter logic [WIDTH-1:0] TAPS       = 8'hB8,
    parameter int               STREAM_LEN = 255,
    localparam int              CNTW       = $clog2(STREAM_LEN + 1)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       seed_load,
    input  logic [CHANNELS*WIDTH-1:0]  seed_in,
    input  logic                       start,
    input  logic [CHANNELS*WIDTH-1:0]  value,
    output logic                       busy,
    output logic                       bit_valid,
    output logic [CHANNELS-1:0]        bits,
    output logic [CNTW-1:0]            count,
    output logic [CHANNELS*CNTW-1:0]   ones,
    output logic                       done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CNTW-1:0] LAST = CNTW'(STREAM_LEN);

    logic [1:0]       state;
    logic [WIDTH-1:0] lfsr     [CHANNELS];
    logic [WIDTH-1:0] value_q  [CHANNELS];
    logic [WIDTH-1:0] seed_fix [CHANNELS];
    logic [CNTW-1:0]  ones_q   [CHANNELS];
    logic [CHANNELS-1:0] cmp;
    logic [CNTW-1:0]  count_inc;

    // The compare sees the pre-step LFSR state; the step happens on the same edge.
    always_comb begin
        cmp = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            cmp[i]      = lfsr[i] < value_q[i];
            seed_fix[i] = (seed_in[i*WIDTH +: WIDTH] == '0) ? WIDTH'(1)
                                                          : seed_in[i*WIDTH +: WIDTH];
        end
    end

    assign count_inc = count + 1'b1;
    assign busy      = (state == S_RUN);
    assign bit_valid = busy;
    assign bits      = busy ? cmp : '0;
    assign done      = (state == S_DONE);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ones
        assign ones[g*CNTW +: CNTW] = ones_q[g];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            count <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                lfsr[i]    <= WIDTH'(i + 1);
                value_q[i] <= '0;
                ones_q[i]  <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (seed_load) begin
                        for (int i = 0; i < CHANNELS; i++) lfsr[i] <= seed_fix[i];
                    end else if (start) begin
                        state <= S_RUN;
                        count <= '0;
                        for (int i = 0; i < CHANNELS; i++) begin
                            value_q[i] <= value[i*WIDTH +: WIDTH];
                            ones_q[i]  <= '0;
                        end
                    end
                end
                S_RUN: begin
                    count <= count_inc;
                    for (int i = 0; i < CHANNELS; i++) begin
                        ones_q[i] <= ones_q[i] + CNTW'(cmp[i]);
                        lfsr[i]   <= {lfsr[i][WIDTH-2:0], ^(lfsr[i] & TAPS)};
                    end
                    if (count_inc == LAST) state <= S_DONE;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sng_lfsr_bank.sv
// Bench for sng_lfsr_bank: a reference LFSR model fills an expected-bit queue at each start,
// and the stream is popped and compared as bit_valid cycles appear.
module tb_sng_lfsr_bank;

    localparam int WIDTH      = 8;
    localparam int CHANNELS   = 2;
    localparam int STREAM_LEN = 255;
    localparam int CNTW       = 8;

    logic                      clk = 1'b0;
    logic                      reset;
    logic                      seed_load;
    logic [CHANNELS*WIDTH-1:0] seed_in;
    logic                      start;
    logic [CHANNELS*WIDTH-1:0] value;
    logic                      busy;
    logic                      bit_valid;
    logic [CHANNELS-1:0]       bits;
    logic [CNTW-1:0]           count;
    logic [CHANNELS*CNTW-1:0]  ones;
    logic                      done;

    logic [CHANNELS-1:0] exp_q[$];
    logic [WIDTH-1:0]    m_lfsr [CHANNELS];
    int checks = 0;
    int errors = 0;

    sng_lfsr_bank dut (
        .clk       (clk),
        .reset     (reset),
        .seed_load (seed_load),
        .seed_in   (seed_in),
        .start     (start),
        .value     (value),
        .busy      (busy),
        .bit_valid (bit_valid),
        .bits      (bits),
        .count     (count),
        .ones      (ones),
        .done      (done)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] x);
        return {x[WIDTH-2:0], ^(x & 8'hB8)};
    endfunction

    task automatic model_reset();
        m_lfsr[0] = 8'h01;
        m_lfsr[1] = 8'h02;
        exp_q.delete();
    endtask

    task automatic apply_reset();
        reset = 1'b1; seed_load = 1'b0; start = 1'b0; seed_in = '0; value = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic check_idle(input string name);
        checks++;
        if (busy !== 1'b0 || bit_valid !== 1'b0 || bits !== '0 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s busy=%b bit_valid=%b bits=%b done=%b exp all 0",
                     name, busy, bit_valid, bits, done);
        end
    endtask

    // Runs one full stream; disturb toggles start/seed_load/value during RUN.
    task automatic run_stream(input logic [WIDTH-1:0] v0, input logic [WIDTH-1:0] v1,
                              input bit disturb);
        logic [WIDTH-1:0]    v [CHANNELS];
        int                  e_ones [CHANNELS];
        logic [CHANNELS-1:0] b;
        logic [CHANNELS-1:0] e;
        int n;
        int cyc;
        v[0] = v0; v[1] = v1;
        for (int ch = 0; ch < CHANNELS; ch++) e_ones[ch] = 0;
        for (int k = 0; k < STREAM_LEN; k++) begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
                b[ch] = m_lfsr[ch] < v[ch];
                e_ones[ch] += int'(b[ch]);
                m_lfsr[ch] = step(m_lfsr[ch]);
            end
            exp_q.push_back(b);
        end
        @(negedge clk);
        value = {v1, v0};
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (bit_valid !== 1'b1) begin
            errors++;
            $display("FAIL first_valid_latency bit_valid=%b exp 1", bit_valid);
        end
        n = 0;
        cyc = 0;
        while (n < STREAM_LEN && cyc < STREAM_LEN + 8) begin
            if (bit_valid === 1'b1) begin
                e = exp_q.pop_front();
                checks++;
                if (bits !== e) begin
                    errors++;
                    $display("FAIL bits[%0d] got=%b exp=%b", n, bits, e);
                end
                n++;
            end else if (n > 0) begin
                checks++;
                errors++;
                $display("FAIL valid_gap at bit %0d bit_valid=%b", n, bit_valid);
            end
            if (disturb) begin
                start     = (cyc % 37 == 5);
                seed_load = (cyc % 53 == 7);
                seed_in   = CHANNELS*WIDTH'($urandom);
                value     = CHANNELS*WIDTH'($urandom);
            end
            cyc++;
            @(negedge clk);
        end
        start = 1'b0; seed_load = 1'b0; value = {v1, v0};
        checks++;
        if (n != STREAM_LEN) begin
            errors++;
            $display("FAIL stream_len got=%0d exp=%0d", n, STREAM_LEN);
        end
        exp_q.delete();
        checks++;
        if (done !== 1'b1 || bit_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse done=%b bit_valid=%b busy=%b exp 1/0/0", done, bit_valid, busy);
        end
        checks++;
        if (count !== CNTW'(STREAM_LEN)) begin
            errors++;
            $display("FAIL count got=%0d exp=%0d", count, STREAM_LEN);
        end
        for (int ch = 0; ch < CHANNELS; ch++) begin
            checks++;
            if (ones[ch*CNTW +: CNTW] !== CNTW'(e_ones[ch])) begin
                errors++;
                $display("FAIL ones[%0d] got=%0d exp=%0d", ch, ones[ch*CNTW +: CNTW], e_ones[ch]);
            end
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || count !== CNTW'(STREAM_LEN)) begin
            errors++;
            $display("FAIL after_done done=%b count=%0d exp 0/%0d", done, count, STREAM_LEN);
        end
    endtask

    task automatic check_ones(input string name, input int e0, input int e1);
        checks++;
        if (ones[CNTW-1:0] !== CNTW'(e0) || ones[2*CNTW-1:CNTW] !== CNTW'(e1)) begin
            errors++;
            $display("FAIL %s ones0=%0d ones1=%0d exp %0d/%0d",
                     name, ones[CNTW-1:0], ones[2*CNTW-1:CNTW], e0, e1);
        end
    endtask

    task automatic load_seeds(input logic [CHANNELS*WIDTH-1:0] s, input bit with_start);
        @(negedge clk);
        seed_in = s; seed_load = 1'b1; start = with_start;
        value = 16'hFFFF;
        @(negedge clk);
        seed_load = 1'b0; start = 1'b0;
        for (int ch = 0; ch < CHANNELS; ch++)
            m_lfsr[ch] = (s[ch*WIDTH +: WIDTH] == '0) ? 8'h01 : s[ch*WIDTH +: WIDTH];
        check_idle("seed_load_idle");
    endtask

    task automatic test_reset();
        apply_reset();
        check_idle("reset_outputs");
        checks++;
        if (count !== '0 || ones !== '0) begin
            errors++;
            $display("FAIL reset_counters count=%0d ones=%h exp 0/0", count, ones);
        end
    endtask

    task automatic test_first_stream();
        run_stream(8'hFF, 8'h03, 1'b0);
        check_ones("t1_ones", 254, 2);
    endtask

    task automatic test_seeded_half();
        load_seeds({8'h5A, 8'h00}, 1'b0);
        run_stream(8'h80, 8'h80, 1'b0);
        check_ones("t2_ones", 127, 127);
    endtask

    task automatic test_extremes();
        run_stream(8'h00, 8'hFF, 1'b0);
        check_ones("t3_ones", 0, 254);
    endtask

    task automatic test_seed_and_start();
        load_seeds({8'h33, 8'h33}, 1'b1);
        @(negedge clk);
        check_idle("t4_start_ignored");
        run_stream(8'h40, 8'hC0, 1'b0);
        check_ones("t4_ones", 63, 191);
    endtask

    task automatic test_back_to_back_disturbed();
        run_stream(8'h80, 8'h80, 1'b1);
        check_ones("t5_ones", 127, 127);
        run_stream(8'h10, 8'hF0, 1'b1);
        check_ones("t5b_ones", 15, 239);
    endtask

    task automatic test_reset_mid_run();
        int cyc;
        @(negedge clk);
        value = 16'h8080; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (count !== 8'd100 && cyc < 300) begin
            cyc++;
            @(negedge clk);
        end
        checks++;
        if (count !== 8'd100) begin
            errors++;
            $display("FAIL t6_reach_100 count=%0d exp 100", count);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_idle("t6_after_reset");
        checks++;
        if (count !== '0 || ones !== '0) begin
            errors++;
            $display("FAIL t6_counters count=%0d ones=%h exp 0/0", count, ones);
        end
        model_reset();
        run_stream(8'h55, 8'hAA, 1'b0);
        check_ones("t6_ones", 84, 169);
    endtask

    initial begin
        reset = 1'b1; seed_load = 1'b0; start = 1'b0; seed_in = '0; value = '0;
        test_reset();
        test_first_stream();
        test_seeded_half();
        test_extremes();
        test_seed_and_start();
        test_back_to_back_disturbed();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, errors);
        $finish;
    end

endmodule
